// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-length burst and locked-transfer holding.
// Grant, owner index and lock flag are registered; everything freezes while HREADY is low.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [3:0] DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;

  state_t                 r_state, w_state_nx;
  logic [3:0]             r_cnt, w_cnt_nx;
  logic [3:0]             r_gidx, w_gidx_nx;
  logic [3:0]             r_ptr;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nx;
  logic [3:0]             r_hmaster;
  logic                   r_hmastlock;
  logic [3:0]             w_rr_idx;
  logic                   w_rr_found;
  logic                   w_rearb;
  logic                   w_glock;
  logic                   w_fixed;
  logic [3:0]             w_beats;
  int                     w_dist;
  int                     w_best;

  assign HGRANT    = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_hmastlock;
  assign w_glock   = |(HLOCK & r_grant);

  // Fixed-length burst decode: beats-1 for the counter.
  always_comb begin
    w_fixed = 1'b1;
    w_beats = 4'd0;
    case (HBURST)
      3'b010, 3'b011: w_beats = 4'd3;
      3'b100, 3'b101: w_beats = 4'd7;
      3'b110, 3'b111: w_beats = 4'd15;
      default:        w_fixed = 1'b0;
    endcase
  end

  // Round-robin search: nearest requester after the pointer, by circular distance.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = DEF_IDX;
    w_best     = int'(NUM_MASTERS);
    w_dist     = 0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      w_dist = (i + 2 * int'(NUM_MASTERS) - int'(r_ptr) - 1) % int'(NUM_MASTERS);
      if (HBUSREQ[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_rr_idx   = 4'(i);
        w_rr_found = 1'b1;
      end
    end
  end

  // FSM next state, beat counter and re-arbitration decision.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rearb    = 1'b0;
    if (HREADY) begin
      if ((HTRANS == TR_NONSEQ) && w_fixed)      w_cnt_nx = w_beats;
      else if ((HTRANS == TR_SEQ) && (r_cnt != 4'd0)) w_cnt_nx = r_cnt - 4'd1;
      else if (HTRANS == TR_IDLE)                w_cnt_nx = 4'd0;
      case (r_state)
        ARB: begin
          if (w_glock)                                   w_state_nx = LOCK;
          else if ((HTRANS == TR_NONSEQ) && w_fixed)     w_state_nx = BURST;
          else                                           w_rearb    = 1'b1;
        end
        BURST: begin
          if (w_glock) begin
            w_state_nx = LOCK;
          end else if ((HTRANS == TR_IDLE) ||
                       ((HTRANS == TR_SEQ) && (r_cnt == 4'd1)) ||
                       ((HTRANS == TR_NONSEQ) && !w_fixed)) begin
            w_state_nx = ARB;
            w_rearb    = 1'b1;
          end
        end
        LOCK: begin
          if (!w_glock) begin
            w_state_nx = ARB;
            w_rearb    = 1'b1;
          end
        end
        default: w_state_nx = ARB;
      endcase
    end
  end

  // Next grant: requester found round-robin, else the default master.
  always_comb begin
    w_grant_nx = r_grant;
    w_gidx_nx  = r_gidx;
    if (w_rearb) begin
      w_gidx_nx = w_rr_idx;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        w_grant_nx[i] = (4'(i) == w_rr_idx);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ARB;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt       <= 4'd0;
      r_grant     <= DEF_GRANT;
      r_gidx      <= DEF_IDX;
      r_ptr       <= DEF_IDX;
      r_hmaster   <= DEF_IDX;
      r_hmastlock <= 1'b0;
    end else if (HREADY) begin
      r_cnt       <= w_cnt_nx;
      r_grant     <= w_grant_nx;
      r_gidx      <= w_gidx_nx;
      r_hmaster   <= r_gidx;
      r_hmastlock <= w_glock;
      if (w_rearb && w_rr_found) r_ptr <= w_rr_idx;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed vectors, a behavioural arbitration model checked every
// cycle, and literal expectations pinning the main scenarios.
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
                         WRAP8 = 3'd4, INCR8 = 3'd5;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [3:0]   HMASTER;
  logic         HMASTLOCK;

  int total = 0;
  int bad   = 0;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, who was last served, beats left, and lock/burst holding.
  int m_owner, m_last, m_rem, e_hm;
  bit m_lockmode, m_inburst, e_ml, m_valid = 0;

  function automatic int burst_beats(input logic [2:0] b);
    if (b == 3'd2 || b == 3'd3) return 4;
    if (b == 3'd4 || b == 3'd5) return 8;
    if (b >= 3'd6)              return 16;
    return 0;
  endfunction

  always @(posedge HCLK) begin : model
    bit rearb;
    bit fixed_start;
    if (HRESET) begin
      m_owner = DEF; m_last = DEF; m_rem = 0;
      m_lockmode = 0; m_inburst = 0; e_hm = DEF; e_ml = 0; m_valid = 1;
    end else if (m_valid && HREADY) begin
      e_hm = m_owner;
      e_ml = HLOCK[m_owner];
      fixed_start = (HTRANS == NONSEQ) && (burst_beats(HBURST) > 0);
      if (fixed_start)                   m_rem = burst_beats(HBURST) - 1;
      else if (HTRANS == SEQ && m_rem > 0) m_rem = m_rem - 1;
      else if (HTRANS == IDLE)           m_rem = 0;
      rearb = 0;
      if (HLOCK[m_owner]) m_lockmode = 1;
      else if (m_lockmode) begin m_lockmode = 0; m_inburst = 0; rearb = 1; end
      else if (m_inburst) begin
        if (m_rem == 0 || (HTRANS == NONSEQ && !fixed_start)) begin
          m_inburst = 0; rearb = 1;
        end
      end
      else if (fixed_start) m_inburst = 1;
      else rearb = 1;
      if (rearb) begin
        m_owner = DEF;
        for (int k = 1; k <= N; k++) begin
          if (HBUSREQ[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            m_last  = m_owner;
            break;
          end
        end
      end
    end
    #2;
    if (m_valid) begin
      chk("grant",     32'(HGRANT),      32'(1 << m_owner));
      chk("hmaster",   32'(HMASTER),     32'(e_hm));
      chk("hmastlock", 32'(HMASTLOCK),   32'(e_ml));
      chk("onehot",    $countones(HGRANT), 32'd1);
    end
  end

  task automatic tick(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    @(negedge HCLK);
    HRESET = rst; HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b0;
    tick(1, 4'b0000, 4'b0000, IDLE, SINGLE, 0);
    tick(1, 4'b0000, 4'b0000, IDLE, SINGLE, 0);
    chk("rst_grant", 32'(HGRANT), 32'b0001);
    chk("rst_hmaster", 32'(HMASTER), 32'd0);
    chk("rst_mlock", 32'(HMASTLOCK), 32'd0);

    // Round robin among masters 1..3 on SINGLE transfers.
    tick(0, 4'b1110, 4'b0000, NONSEQ, SINGLE, 1);
    chk("rr1_grant", 32'(HGRANT), 32'b0010); chk("rr1_hm", 32'(HMASTER), 32'd0);
    tick(0, 4'b1110, 4'b0000, NONSEQ, SINGLE, 1);
    chk("rr2_grant", 32'(HGRANT), 32'b0100); chk("rr2_hm", 32'(HMASTER), 32'd1);
    tick(0, 4'b1110, 4'b0000, NONSEQ, SINGLE, 1);
    chk("rr3_grant", 32'(HGRANT), 32'b1000); chk("rr3_hm", 32'(HMASTER), 32'd2);
    tick(0, 4'b1110, 4'b0000, NONSEQ, SINGLE, 1);
    chk("rr4_grant", 32'(HGRANT), 32'b0010); chk("rr4_hm", 32'(HMASTER), 32'd3);

    // No requests -> default master; wait states freeze the grant.
    tick(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
    chk("dflt_grant", 32'(HGRANT), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      tick(0, 4'b0100, 4'b0000, IDLE, SINGLE, 0);
      chk("wait_grant", 32'(HGRANT), 32'b0001);
    end
    tick(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1);
    chk("wait_rel_grant", 32'(HGRANT), 32'b0100);

    // Master 2 INCR4 with BUSY and a wait state while master 1 requests.
    tick(0, 4'b0110, 4'b0000, NONSEQ, INCR4, 1);
    tick(0, 4'b0110, 4'b0000, SEQ,    INCR4, 1);
    tick(0, 4'b0110, 4'b0000, BUSY,   INCR4, 1);
    tick(0, 4'b0110, 4'b0000, SEQ,    INCR4, 0);
    chk("b4_mid_grant", 32'(HGRANT), 32'b0100);
    tick(0, 4'b0110, 4'b0000, SEQ,    INCR4, 1);
    chk("b4_pre_grant", 32'(HGRANT), 32'b0100);
    tick(0, 4'b0110, 4'b0000, SEQ,    INCR4, 1);
    chk("b4_last_grant", 32'(HGRANT), 32'b0010);

    // Master 1 WRAP8 terminated early by IDLE after two beats.
    tick(0, 4'b0110, 4'b0000, NONSEQ, WRAP8, 1);
    tick(0, 4'b0110, 4'b0000, SEQ,    WRAP8, 1);
    chk("w8_hold_grant", 32'(HGRANT), 32'b0010);
    tick(0, 4'b0110, 4'b0000, IDLE,   WRAP8, 1);
    chk("w8_idle_grant", 32'(HGRANT), 32'b0100);

    // Master 3 locked across two SINGLEs with everyone requesting.
    tick(0, 4'b1111, 4'b1000, NONSEQ, SINGLE, 1);
    chk("lk_grant0", 32'(HGRANT), 32'b1000);
    tick(0, 4'b1111, 4'b1000, NONSEQ, SINGLE, 1);
    chk("lk_grant1", 32'(HGRANT), 32'b1000); chk("lk_ml1", 32'(HMASTLOCK), 32'd1);
    tick(0, 4'b1111, 4'b1000, NONSEQ, SINGLE, 1);
    chk("lk_grant2", 32'(HGRANT), 32'b1000); chk("lk_ml2", 32'(HMASTLOCK), 32'd1);
    tick(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 0);
    chk("lk_wait_grant", 32'(HGRANT), 32'b1000);
    tick(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1);
    chk("lk_rel_grant", 32'(HGRANT), 32'b0001); chk("lk_rel_ml", 32'(HMASTLOCK), 32'd0);

    // Master 1 INCR8 interrupted by reset at beat 3, with HREADY low.
    tick(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1);
    chk("i8_grant", 32'(HGRANT), 32'b0010);
    tick(0, 4'b0010, 4'b0000, NONSEQ, INCR8, 1);
    tick(0, 4'b0010, 4'b0000, SEQ,    INCR8, 1);
    tick(0, 4'b0010, 4'b0000, SEQ,    INCR8, 1);
    chk("i8_hold_grant", 32'(HGRANT), 32'b0010);
    tick(1, 4'b0010, 4'b0000, SEQ,    INCR8, 0);
    chk("i8_rst_grant", 32'(HGRANT), 32'b0001);
    chk("i8_rst_hm", 32'(HMASTER), 32'd0);
    chk("i8_rst_ml", 32'(HMASTLOCK), 32'd0);
    tick(0, 4'b0010, 4'b0000, SEQ,    INCR8, 1);
    chk("i8_arb_grant", 32'(HGRANT), 32'b0010);

    // Undefined-length INCR re-arbitrates every beat.
    tick(0, 4'b0011, 4'b0000, NONSEQ, INCR, 1);
    chk("incr_grant0", 32'(HGRANT), 32'b0001);
    tick(0, 4'b0011, 4'b0000, SEQ,    INCR, 1);
    chk("incr_grant1", 32'(HGRANT), 32'b0010);
    tick(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1);
    tick(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
